// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, state encoding and iteration limit for the sequential multiplier
package mult_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/_16bit_adder_structural.sv
// rtl/_16bit_adder_structural.sv - 16-bit ripple-carry adder built from full-adder cells
module _16bit_adder_structural (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  // one full-adder cell per bit, carry rippling from bit 0 upward
  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[16];

endmodule

// File: rtl/seq_mult_16bit.sv
// rtl/seq_mult_16bit.sv - shift-and-add 16x16->32 unsigned multiplier time-sharing one ripple adder
module seq_mult_16bit
  import mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] s;
  logic             c;

  // partial product: multiplicand only when the current multiplier bit is set
  assign add_b = lo[0] ? m : '0;

  _16bit_adder_structural u_adder (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (s),
    .cout (c)
  );

  // control FSM and datapath registers; {hi,lo} shifts right by one each RUN cycle with carry entering at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          {hi, lo} <= {c, s, lo[WIDTH-1:1]};
          cnt      <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            product <= {c, s, lo[WIDTH-1:1]};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_16bit.sv
// tb/tb_seq_mult_16bit.sv - directed and random self-checking bench for seq_mult_16bit
module tb_seq_mult_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_prod;
  logic        prev_done;

  seq_mult_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // done must never stay high for two consecutive cycles
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) check("done_single", {31'b0, prev_done}, 32'd0);
    prev_done = done;
  end

  // one multiply: start pulse, scramble inputs after acceptance, then check latency, busy width, hold and result
  task automatic do_mult(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp);
    int cyc;
    int busy_cnt;
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    check({tag, "_hold"}, product, last_prod);
    cyc      = 1;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_product"}, product, exp);
    last_prod = exp;
    @(negedge clk);
  endtask

  initial begin
    int          cyc;
    int          done_cnt;
    logic [15:0] rx;
    logic [15:0] ry;

    n_checks  = 0;
    n_fail    = 0;
    last_prod = 32'd0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_mult("m3x5", 16'h0003, 16'h0005, 32'h0000000F);
    do_mult("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    do_mult("m8000x2", 16'h8000, 16'h0002, 32'h00010000);
    do_mult("m0x1234", 16'h0000, 16'h1234, 32'h00000000);

    // back-to-back: start held high through RUN and DONE
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0010;
    @(negedge clk);
    a   = 16'hFFFF;
    b   = 16'hFFFF;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_latency", 32'(cyc), 32'd17);
    check("b2b_first_product", product, 32'h00012340);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", {31'b0, busy}, 32'd1);
    check("b2b_second_hold", product, 32'h00012340);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_second_latency", 32'(cyc), 32'd17);
    check("b2b_second_product", product, 32'hFFFE0001);
    last_prod = 32'hFFFE0001;
    @(negedge clk);

    // reset in the middle of a RUN
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_product", product, 32'd0);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    last_prod = 32'd0;
    do_mult("m00ff", 16'h00FF, 16'h00FF, 32'h0000FE01);

    // random operand pairs against a*b
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      do_mult("rand", rx, ry, {16'b0, rx} * {16'b0, ry});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
